disp_sweep_tx: RTL and testbench

Disparity sweep transmitter for the stereo distance path. It holds one reference window of left-image pixels and one search line of right-image pixels. On command it computes the sum of absolute differences (SAD) for every disparity, and drives each cost with its index onto the candidate bus (startsig/update/cost/idx) consumed by the minimum-cost selector. It is the producing end of that bus: it arms the selector, streams all candidates, then pulses the publish strobe so the selector outputs the winning disparity.

---
 rtl/disp_sweep_tx.sv | 160 ++++++++++++++++
 tb/tb_disp_sweep_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/disp_sweep_tx.sv
// Disparity sweep transmitter: holds a reference window and a search line, computes SAD
// for every disparity and streams each candidate onto the selector's startsig/update bus.
module disp_sweep_tx #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned WIN    = 8,
    parameter int unsigned DISP_W = 6,
    parameter int unsigned COST_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic              pix_sel,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              go,
    output logic              startsig,
    output logic              update,
    output logic [COST_W-1:0] cost,
    output logic [DISP_W-1:0] idx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NDISP = 2 ** DISP_W;
    localparam int unsigned SLEN  = WIN + NDISP - 1;
    localparam int unsigned ACC_W = $clog2(WIN * (2 ** PIX_W - 1) + 1);
    localparam int unsigned P_W   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int unsigned S_W   = $clog2(SLEN);

    typedef enum logic [3:0] {
        StIdle,
        StArm,
        StArmGap,
        StAcc,
        StSetup,
        StStrobe,
        StGap,
        StPub,
        StFin
    } state_e;

    state_e state_q, state_d;

    logic [PIX_W-1:0]  ref_q  [WIN];
    logic [PIX_W-1:0]  srch_q [SLEN];
    logic [DISP_W-1:0] d_q, d_d;
    logic [P_W-1:0]    p_q, p_d;
    logic [ACC_W-1:0]  acc_q, acc_d;

    logic              startsig_q, update_q, busy_q, done_q;
    logic [COST_W-1:0] cost_q;
    logic [DISP_W-1:0] idx_q;

    logic [S_W-1:0]   sidx;
    logic [PIX_W-1:0] rpix, spix, absdiff;
    logic [ACC_W-1:0] acc_sum;

    // Pixel buffers: each load shifts toward index 0, so element[i] ends up as the i-th pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN; i++) ref_q[i] <= '0;
            for (int i = 0; i < SLEN; i++) srch_q[i] <= '0;
        end else if (state_q == StIdle && pix_valid) begin
            if (!pix_sel) begin
                for (int i = 0; i < WIN - 1; i++) ref_q[i] <= ref_q[i+1];
                ref_q[WIN-1] <= pix_data;
            end else begin
                for (int i = 0; i < SLEN - 1; i++) srch_q[i] <= srch_q[i+1];
                srch_q[SLEN-1] <= pix_data;
            end
        end
    end

    assign sidx    = S_W'(d_q) + S_W'(p_q);
    assign rpix    = ref_q[p_q];
    assign spix    = srch_q[sidx];
    assign absdiff = (rpix >= spix) ? (rpix - spix) : (spix - rpix);
    assign acc_sum = acc_q + ACC_W'(absdiff);

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        p_d     = p_q;
        acc_d   = acc_q;
        unique case (state_q)
            StIdle:   if (go) state_d = StArm;
            StArm:    state_d = StArmGap;
            StArmGap: begin
                d_d     = '0;
                p_d     = '0;
                acc_d   = '0;
                state_d = StAcc;
            end
            StAcc: begin
                acc_d = acc_sum;
                p_d   = p_q + 1'b1;
                if (p_q == P_W'(WIN - 1)) begin
                    p_d     = '0;
                    state_d = StSetup;
                end
            end
            StSetup:  state_d = StStrobe;
            StStrobe: state_d = StGap;
            StGap: begin
                acc_d = '0;
                if (d_q == DISP_W'(NDISP - 1)) begin
                    state_d = StPub;
                end else begin
                    d_d     = d_q + 1'b1;
                    state_d = StAcc;
                end
            end
            StPub:    state_d = StFin;
            StFin:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            d_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
        end
    end

    // Outputs are decoded from the next state so each strobe lines up with its own state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            startsig_q <= 1'b0;
            update_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cost_q     <= '0;
            idx_q      <= '0;
        end else begin
            startsig_q <= (state_d == StArm) || (state_d == StPub);
            update_q   <= (state_d == StStrobe);
            busy_q     <= (state_d != StIdle);
            done_q     <= (state_d == StFin);
            if (state_q == StAcc && state_d == StSetup) begin
                cost_q <= COST_W'(acc_sum);
                idx_q  <= d_q;
            end
        end
    end

    assign startsig = startsig_q;
    assign update   = update_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cost     = cost_q;
    assign idx      = idx_q;

endmodule

// File: tb/tb_disp_sweep_tx.sv
// Directed bench for disp_sweep_tx: flat, ramp, saturation, busy guards and reset abort,
// checking strobe timing, candidate costs and the selector's winning disparity.
module tb_disp_sweep_tx;

    localparam int WIN   = 8;
    localparam int NDISP = 64;
    localparam int SLEN  = 71;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_sel = 1'b0;
    logic [7:0]  pix_data = 8'h00;
    logic        go = 1'b0;
    logic        startsig, update, busy, done;
    logic [17:0] cost;
    logic [5:0]  idx;

    always #5 clk = ~clk;

    disp_sweep_tx dut (
        .clk      (clk),
        .rst      (rst),
        .pix_valid(pix_valid),
        .pix_sel  (pix_sel),
        .pix_data (pix_data),
        .go       (go),
        .startsig (startsig),
        .update   (update),
        .cost     (cost),
        .idx      (idx),
        .busy     (busy),
        .done     (done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor, sampled on the falling edge.
    int   n_st = 0, n_upd = 0, n_done = 0, n_ov = 0;
    int   st_cyc   [256];
    int   upd_cyc  [512];
    int   cost_log [512];
    int   idx_log  [512];
    int   done_cyc [64];
    logic prev_upd = 1'b0, prev_st = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (startsig) begin
                st_cyc[n_st % 256] = cyc;
                n_st++;
            end
            if (update) begin
                upd_cyc[n_upd % 512]  = cyc;
                cost_log[n_upd % 512] = int'(cost);
                idx_log[n_upd % 512]  = int'(idx);
                n_upd++;
            end
            if (done) begin
                done_cyc[n_done % 64] = cyc;
                n_done++;
            end
            if (startsig && update) n_ov++;
            if (update && prev_upd) n_ov++;
            if (startsig && prev_st) n_ov++;
            prev_upd = update;
            prev_st  = startsig;
        end
    end

    int n_chk = 0, n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [7:0] rf [WIN];
    logic [7:0] sr [SLEN];
    int exp_cost [NDISP];
    int go_cyc, b_st, b_upd, b_done, b_ov, last_win;

    task automatic load_all();
        for (int p = 0; p < WIN; p++) begin
            @(posedge clk); #1;
            pix_valid = 1'b1; pix_sel = 1'b0; pix_data = rf[p];
        end
        for (int i = 0; i < SLEN; i++) begin
            @(posedge clk); #1;
            pix_valid = 1'b1; pix_sel = 1'b1; pix_data = sr[i];
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic model();
        for (int d = 0; d < NDISP; d++) begin
            int s;
            s = 0;
            for (int p = 0; p < WIN; p++) begin
                int a, b;
                a = int'(rf[p]);
                b = int'(sr[d+p]);
                s += (a > b) ? a - b : b - a;
            end
            exp_cost[d] = s;
        end
    endtask

    task automatic start_sweep();
        b_st = n_st; b_upd = n_upd; b_done = n_done; b_ov = n_ov;
        @(posedge clk); #1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        go_cyc = cyc;
    endtask

    // Waits for done with a cycle budget; guard=1 pokes go and ref loads while busy.
    task automatic wait_done(input bit guard);
        for (int k = 0; k < 800 && n_done == b_done; k++) begin
            @(posedge clk); #1;
            if (guard) begin
                pix_valid = (k >= 50 && k < 60);
                pix_sel   = 1'b0;
                pix_data  = 8'hAA;
                go        = (k == 200 || k == 400);
            end
        end
        pix_valid = 1'b0;
        go = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic verify(input string tag);
        int cbad, ibad, best, ebest;
        check({tag, "_nst"}, n_st - b_st, 2);
        check({tag, "_nupd"}, n_upd - b_upd, 64);
        check({tag, "_ndone"}, n_done - b_done, 1);
        check({tag, "_arm_t"}, st_cyc[b_st % 256] - go_cyc + 1, 1);
        check({tag, "_pub_t"}, st_cyc[(b_st + 1) % 256] - go_cyc + 1, 707);
        check({tag, "_upd0_t"}, upd_cyc[b_upd % 512] - go_cyc + 1, 12);
        check({tag, "_done_t"}, done_cyc[b_done % 64] - go_cyc + 1, 708);
        check({tag, "_busy_end"}, int'(busy), 0);
        check({tag, "_spacing"}, n_ov - b_ov, 0);
        cbad = 0; ibad = 0;
        for (int d = 0; d < NDISP; d++) begin
            if (cost_log[(b_upd + d) % 512] != exp_cost[d]) cbad++;
            if (idx_log[(b_upd + d) % 512] != d) ibad++;
            if (upd_cyc[(b_upd + d) % 512] - go_cyc + 1 != 12 + 11 * d) ibad++;
        end
        check({tag, "_cost_errs"}, cbad, 0);
        check({tag, "_idx_errs"}, ibad, 0);
        best = 0; ebest = 0;
        for (int d = 1; d < NDISP; d++) begin
            if (cost_log[(b_upd + d) % 512] < cost_log[(b_upd + best) % 512]) best = d;
            if (exp_cost[d] < exp_cost[ebest]) ebest = d;
        end
        last_win = idx_log[(b_upd + best) % 512];
        check({tag, "_winner"}, last_win, ebest);
    endtask

    task automatic set_ramp();
        for (int p = 0; p < WIN; p++) rf[p] = 8'(17 + p);
        for (int i = 0; i < SLEN; i++) sr[i] = 8'(i);
    endtask

    initial begin
        int bs, bu;
        // Reset state, then quiet after release
        #23;
        check("rst_outputs", int'({startsig, update, busy, done, cost, idx}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bs = n_st; bu = n_upd;
        repeat (10) @(posedge clk);
        #1;
        check("rst_quiet", (n_st - bs) + (n_upd - bu), 0);

        // Flat images
        for (int p = 0; p < WIN; p++) rf[p] = 8'd0;
        for (int i = 0; i < SLEN; i++) sr[i] = 8'd0;
        load_all(); model();
        start_sweep(); wait_done(1'b0); verify("flat");
        check("flat_cost5", cost_log[(b_upd + 5) % 512], 0);
        check("flat_win0", last_win, 0);

        // Ramp match at disparity 17
        set_ramp(); load_all(); model();
        start_sweep(); wait_done(1'b0); verify("ramp");
        check("ramp_c17", cost_log[(b_upd + 17) % 512], 0);
        check("ramp_c16", cost_log[(b_upd + 16) % 512], 8);
        check("ramp_c18", cost_log[(b_upd + 18) % 512], 8);
        check("ramp_c0", cost_log[b_upd % 512], 136);
        check("ramp_win17", last_win, 17);

        // go and ref loads while busy must be ignored
        start_sweep(); wait_done(1'b1); verify("guard");
        check("guard_win17", last_win, 17);
        start_sweep(); wait_done(1'b0); verify("after_guard");

        // Saturation
        for (int p = 0; p < WIN; p++) rf[p] = 8'd255;
        for (int i = 0; i < SLEN; i++) sr[i] = 8'd0;
        load_all(); model();
        start_sweep(); wait_done(1'b0); verify("sat");
        check("sat_c40", cost_log[(b_upd + 40) % 512], 2040);
        check("sat_cost_out", int'(cost), 2040);
        check("sat_win0", last_win, 0);

        // Reset mid-sweep, mid-cycle
        set_ramp(); load_all(); model();
        start_sweep();
        repeat (99) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_outputs", int'({startsig, update, busy, done, cost, idx}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bs = n_st; bu = n_upd;
        repeat (10) @(posedge clk);
        #1;
        check("abort_quiet", (n_st - bs) + (n_upd - bu), 0);
        check("abort_busy", int'(busy), 0);
        load_all();
        start_sweep(); wait_done(1'b0); verify("post_abort");
        check("post_abort_win", last_win, 17);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
